// File: rtl/hash_control_unit_pkg.sv
// Shared types and constants for the byte-serial hash control unit.
package hash_control_unit_pkg;

  localparam int unsigned N_ROUNDS_DEF = 8;
  localparam logic [31:0] H_INIT       = 32'h32FE1AF3;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    CHECK,
    WAIT_BYTE,
    MSG_ROUND,
    LEN_ROUND,
    DONE,
    ERROR
  } ctrl_state_t;

endpackage

// File: rtl/hash_control_unit_if.sv
// Message byte stream from the source: valid/last forward, ready back.
interface hash_control_unit_if;
  logic msg_valid;
  logic msg_last;
  logic msg_ready;

  modport master (output msg_valid, output msg_last, input msg_ready);
  modport slave  (input msg_valid, input msg_last, output msg_ready);
endinterface

// File: rtl/hash_control_unit_round_counter.sv
// Round index counter shared by the message and length-absorb phases.
module hash_control_unit_round_counter #(
  parameter int unsigned N_ROUNDS = 8,
  parameter int unsigned RI_W     = $clog2(N_ROUNDS)
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  output logic [RI_W-1:0] count,
  output logic            tc
);

  always_ff @(posedge clock or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count + 1'b1;
  end

  // N_ROUNDS is a power of two, so the increment past tc wraps to 0 by itself.
  assign tc = (count == RI_W'(N_ROUNDS - 1));

endmodule

// File: rtl/hash_control_unit.sv
// Control FSM for the byte-serial hash datapath: message rounds per byte,
// then length-absorb rounds, then digest-ready.
module hash_control_unit
  import hash_control_unit_pkg::*;
#(
  parameter int unsigned N_ROUNDS = N_ROUNDS_DEF,
  parameter int unsigned RI_W     = $clog2(N_ROUNDS)
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                start,
  hash_control_unit_if.slave  msg,
  input  logic                case_R_c_zero,
  output logic                op_start,
  output logic                validate_input,
  output logic                switch_operation,
  output logic                validate_R_h,
  output logic [RI_W-1:0]     R_i,
  output logic                busy,
  output logic                hash_ready,
  output logic                hash_error
);

  ctrl_state_t state, state_n;
  logic        last_q;
  logic        ready;
  logic        cnt_clr, cnt_en, tc;
  logic        err_set;

  hash_control_unit_round_counter #(
    .N_ROUNDS (N_ROUNDS),
    .RI_W     (RI_W)
  ) u_round_counter (
    .clock (clock),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (R_i),
    .tc    (tc)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      last_q           <= 1'b0;
      hash_error       <= 1'b0;
      switch_operation <= 1'b0;
    end else begin
      state            <= state_n;
      // Registered alongside the state so the phase select never glitches.
      switch_operation <= (state_n == LEN_ROUND);
      if (err_set)
        hash_error <= 1'b1;
      if (state == INIT)
        last_q <= 1'b0;
      else if (state == WAIT_BYTE && msg.msg_valid)
        last_q <= msg.msg_last;
    end
  end

  always_comb begin
    state_n        = state;
    op_start       = 1'b0;
    validate_input = 1'b0;
    validate_R_h   = 1'b0;
    ready          = 1'b0;
    cnt_clr        = 1'b0;
    cnt_en         = 1'b0;
    err_set        = 1'b0;
    busy           = 1'b0;
    hash_ready     = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          state_n = INIT;
      end
      INIT: begin
        op_start = 1'b1;
        busy     = 1'b1;
        cnt_clr  = 1'b1;
        state_n  = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (case_R_c_zero) begin
          state_n = WAIT_BYTE;
        end else begin
          err_set = 1'b1;
          state_n = ERROR;
        end
      end
      WAIT_BYTE: begin
        busy  = 1'b1;
        ready = 1'b1;
        if (msg.msg_valid) begin
          validate_input = 1'b1;
          cnt_clr        = 1'b1;
          state_n        = MSG_ROUND;
        end
      end
      MSG_ROUND: begin
        busy         = 1'b1;
        validate_R_h = 1'b1;
        cnt_en       = 1'b1;
        if (tc)
          state_n = last_q ? LEN_ROUND : WAIT_BYTE;
      end
      LEN_ROUND: begin
        busy         = 1'b1;
        validate_R_h = 1'b1;
        cnt_en       = 1'b1;
        if (tc)
          state_n = DONE;
      end
      DONE: begin
        hash_ready = 1'b1;
        if (start)
          state_n = INIT;
      end
      ERROR: begin
        state_n = ERROR;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign msg.msg_ready = ready;

endmodule

// File: tb/tb_hash_control_unit.sv
// Bench for hash_control_unit: toy datapath driven by the DUT strobes,
// digest compared against a whole-message software model.
module tb_hash_control_unit;
  import hash_control_unit_pkg::*;

  localparam int unsigned NR   = N_ROUNDS_DEF;
  localparam int unsigned RI_W = 3;

  logic            clock = 1'b0;
  logic            rst;
  logic            start;
  logic            case_R_c_zero;
  logic            op_start, validate_input, switch_operation, validate_R_h;
  logic [RI_W-1:0] R_i;
  logic            busy, hash_ready, hash_error;
  logic [7:0]      msg_data;
  logic            force_bad;

  hash_control_unit_if mif ();

  hash_control_unit #(
    .N_ROUNDS (NR),
    .RI_W     (RI_W)
  ) dut (
    .clock            (clock),
    .rst              (rst),
    .start            (start),
    .msg              (mif),
    .case_R_c_zero    (case_R_c_zero),
    .op_start         (op_start),
    .validate_input   (validate_input),
    .switch_operation (switch_operation),
    .validate_R_h     (validate_R_h),
    .R_i              (R_i),
    .busy             (busy),
    .hash_ready       (hash_ready),
    .hash_error       (hash_error)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mix(logic [31:0] h, logic [31:0] d, logic [3:0] r);
    return {h[26:0], h[31:27]} ^ (d * 32'h01000193 + {28'b0, r});
  endfunction

  // Toy datapath: byte register, byte counter and R_h, all driven by DUT strobes.
  logic [31:0] rh;
  logic [7:0]  byte_r;
  int unsigned dp_cnt;

  always @(posedge clock or posedge rst) begin
    if (rst) begin
      rh     <= '0;
      byte_r <= '0;
      dp_cnt <= 0;
    end else begin
      if (op_start) begin
        rh     <= H_INIT;
        dp_cnt <= 0;
      end
      if (validate_input) begin
        byte_r <= msg_data;
        dp_cnt <= dp_cnt + 1;
      end
      if (validate_R_h)
        rh <= switch_operation ? mix(rh, dp_cnt, {1'b1, R_i})
                               : mix(rh, {24'b0, byte_r}, {1'b0, R_i});
    end
  end

  assign case_R_c_zero = (dp_cnt == 0) && !force_bad;

  // Reference: every byte gets NR rounds, then NR rounds absorb the length.
  function automatic logic [31:0] model_digest(logic [7:0] b[$]);
    logic [31:0] h = H_INIT;
    foreach (b[k])
      for (int r = 0; r < int'(NR); r++)
        h = mix(h, {24'b0, b[k]}, 4'(r));
    for (int r = 0; r < int'(NR); r++)
      h = mix(h, b.size(), 4'(r + int'(NR)));
    return h;
  endfunction

  // Strobe monitor: event counts and per-cycle rule violations.
  int unsigned vi_n = 0, op_n = 0, msg_n = 0, len_n = 0, ri_err = 0, excl_err = 0;
  int unsigned ri_exp = 0;

  always @(negedge clock) begin
    if (rst) begin
      ri_exp <= 0;
    end else begin
      if (validate_input) vi_n <= vi_n + 1;
      if (op_start)       op_n <= op_n + 1;
      if (validate_R_h) begin
        if (switch_operation) len_n <= len_n + 1;
        else                  msg_n <= msg_n + 1;
        if (int'(R_i) != int'(ri_exp)) ri_err <= ri_err + 1;
        ri_exp <= (ri_exp + 1) % NR;
      end
      if ((validate_input && validate_R_h) ||
          (op_start && (validate_input || validate_R_h)) ||
          (switch_operation && !validate_R_h) ||
          (mif.msg_ready && !busy) ||
          (validate_input && !mif.msg_ready))
        excl_err <= excl_err + 1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [10:0] all_outs();
    return {op_start, validate_input, switch_operation, validate_R_h, R_i,
            busy, hash_ready, hash_error, mif.msg_ready};
  endfunction

  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int t = 0;
    while (!mif.msg_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    check({tag, " ready timeout"}, mif.msg_ready, 1);
  endtask

  task automatic run_msg(input logic [7:0] b[$], input int gap[$], input bit disturb,
                         input int exp_msg, input int exp_lat, input string tag,
                         output logic [31:0] digest);
    int unsigned vi0, op0, m0, l0, re0, ex0;
    int lat;
    @(negedge clock);
    vi0 = vi_n; op0 = op_n; m0 = msg_n; l0 = len_n; re0 = ri_err; ex0 = excl_err;
    pulse_start();
    check({tag, " op_start"}, op_start, 1);
    check({tag, " ready low in INIT"}, hash_ready, 0);
    for (int i = 0; i < b.size(); i++) begin
      wait_ready(tag);
      repeat (gap[i]) @(negedge clock);
      msg_data      = b[i];
      mif.msg_valid = 1'b1;
      mif.msg_last  = (i == b.size() - 1);
      @(negedge clock);
      mif.msg_valid = 1'b0;
      mif.msg_last  = 1'b0;
      if (disturb && i == 1) begin
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
    end
    lat = 1;
    while (!hash_ready && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    @(negedge clock);
    check({tag, " op_start count"}, op_n - op0, 1);
    check({tag, " validate_input count"}, vi_n - vi0, b.size());
    check({tag, " msg rounds"}, msg_n - m0, exp_msg);
    check({tag, " len rounds"}, len_n - l0, NR);
    check({tag, " R_i sequence errors"}, ri_err - re0, 0);
    check({tag, " strobe rule errors"}, excl_err - ex0, 0);
    check({tag, " digest"}, rh, model_digest(b));
    check({tag, " done flags"}, {busy, hash_ready}, 2'b01);
    digest = rh;
  endtask

  typedef struct {
    int         n;
    logic [7:0] b[6];
    int         g[6];
    bit         disturb;
    int         exp_msg;
    int         exp_lat;
  } vec_t;

  vec_t        tbl[4];
  logic [31:0] dig[4];
  logic [31:0] d;
  logic [7:0]  bq[$];
  int          gq[$];

  initial begin
    rst = 1'b1; start = 1'b0; force_bad = 1'b0; msg_data = '0;
    mif.msg_valid = 1'b0; mif.msg_last = 1'b0;

    tbl[0] = '{1, '{8'hA5, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0}, 1'b0, 8,  2*NR+1};
    tbl[1] = '{3, '{8'h01, 8'h02, 8'h03, 0, 0, 0}, '{0, 5, 1, 0, 0, 0}, 1'b0, 24, 2*NR+1};
    tbl[2] = '{3, '{8'h01, 8'h02, 8'h03, 0, 0, 0}, '{0, 5, 1, 0, 0, 0}, 1'b1, 24, 2*NR+1};
    tbl[3] = '{5, '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h42, 0}, '{2, 0, 3, 0, 1, 0}, 1'b0, 40, 2*NR+1};

    @(negedge clock);
    check("outputs in reset", all_outs(), 0);
    rst = 1'b0;
    @(negedge clock);
    check("outputs after reset", all_outs(), 0);

    for (int v = 0; v < 4; v++) begin
      bq.delete(); gq.delete();
      for (int k = 0; k < tbl[v].n; k++) begin
        bq.push_back(tbl[v].b[k]);
        gq.push_back(tbl[v].g[k]);
      end
      run_msg(bq, gq, tbl[v].disturb, tbl[v].exp_msg, tbl[v].exp_lat, $sformatf("vec%0d", v), d);
      dig[v] = d;
    end
    check("disturbed digest equals undisturbed", dig[2], dig[1]);

    // Async reset in the middle of the length phase.
    begin
      int t = 0;
      pulse_start();
      wait_ready("rst_mid");
      msg_data = 8'h77; mif.msg_valid = 1'b1; mif.msg_last = 1'b1;
      @(negedge clock);
      mif.msg_valid = 1'b0; mif.msg_last = 1'b0;
      while (!(switch_operation && R_i == 3'd4) && t < 50) begin
        @(negedge clock);
        t++;
      end
      check("reached LEN R_i=4", {switch_operation, R_i}, {1'b1, 3'd4});
      rst = 1'b1;
      #1;
      check("outputs on async reset", all_outs(), 0);
      @(negedge clock) rst = 1'b0;
      @(negedge clock);
      check("outputs after mid reset", all_outs(), 0);
      bq = '{8'h11, 8'h22}; gq = '{1, 0};
      run_msg(bq, gq, 1'b0, 16, 2*NR+1, "after_rst", d);
    end

    // Datapath fails to clear: sticky error, nothing else moves until reset.
    begin
      int unsigned vi0, op0, m0;
      force_bad = 1'b1;
      pulse_start();
      @(negedge clock);
      @(negedge clock);
      check("error raised", hash_error, 1);
      vi0 = vi_n; op0 = op_n; m0 = msg_n + len_n;
      mif.msg_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
        start = k[0];
        @(negedge clock);
        check("ready low in ERROR", mif.msg_ready, 0);
      end
      start = 1'b0; mif.msg_valid = 1'b0; force_bad = 1'b0;
      @(negedge clock);
      check("error sticky", {hash_error, busy, hash_ready}, 3'b100);
      check("no strobes in ERROR", (vi_n - vi0) + (op_n - op0) + (msg_n + len_n - m0), 0);
      rst = 1'b1;
      #1;
      check("error cleared by reset", hash_error, 0);
      @(negedge clock) rst = 1'b0;
    end

    for (int it = 0; it < 20; it++) begin
      int n = $urandom_range(1, 6);
      bq.delete(); gq.delete();
      for (int k = 0; k < n; k++) begin
        bq.push_back(8'($urandom));
        gq.push_back($urandom_range(0, 3));
      end
      run_msg(bq, gq, 1'b0, n * NR, 2*NR+1, $sformatf("rand%0d", it), d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
